// File: rtl/crossbar4x4read_pkg.sv
// Shared definitions for the banked-memory read/write crossbars: sizes,
// the in-flight read tag and the bank-select helper.
package crossbar_pkg;

   localparam int NPORT = 4;
   localparam int NBANK = 4;
   localparam int BSELW = 2;
   localparam int ADDRW = 16;
   localparam int WL    = 32;

   typedef struct packed {
      logic             valid;
      logic [BSELW-1:0] bsel;
   } tag_t;

   // Single place that defines the bank interleave (low address bits).
   function automatic logic [BSELW-1:0] banksel_of(input logic [BSELW-1:0] addr_lo);
      return addr_lo;
   endfunction

endpackage

// File: rtl/crossbar4x4read_if.sv
// Requester and bank-side signals of the read crossbar. Handshake: a port whose
// req is high and stall low in a cycle has issued; with stall high it must hold req/address.
interface crossbar4x4read_if #(
   parameter int ADDRW = crossbar_pkg::ADDRW,
   parameter int WL    = crossbar_pkg::WL
);
   import crossbar_pkg::*;

   logic                   ena;
   logic [NPORT-1:0]       req;
   logic [ADDRW-1:0]       address    [NPORT];
   logic [NPORT-1:0]       stall;
   logic [ADDRW-BSELW-1:0] addressout [NBANK];
   logic [NBANK-1:0]       bankren;
   logic [WL-1:0]          bankdata   [NBANK];
   logic [WL-1:0]          rddata     [NPORT];
   logic [NPORT-1:0]       rdvalid;

   modport slave (
      input  ena, req, address, bankdata,
      output stall, addressout, bankren, rddata, rdvalid
   );

   modport master (
      output ena, req, address, bankdata,
      input  stall, addressout, bankren, rddata, rdvalid
   );

endinterface

// File: rtl/crossbar_rd_tagpipe.sv
// Fixed-depth delay line for one port's read tag; its depth matches the
// bank read latency so the tag arrives together with the bank data.
module crossbar_rd_tagpipe
   import crossbar_pkg::*;
#(
   parameter int RDLAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  tag_t din,
   output tag_t dout
);

   tag_t stage [RDLAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < RDLAT; k++) stage[k] <= '0;
      end else begin
         stage[0] <= din;
         for (int k = 1; k < RDLAT; k++) stage[k] <= stage[k-1];
      end
   end

   assign dout = stage[RDLAT-1];

endmodule

// File: rtl/crossbar4x4read.sv
// 4-port read crossbar onto 4 interleaved banks: fixed-priority bank arbitration,
// per-port tag pipeline sized to the bank latency, and a registered return mux.
module crossbar4x4read #(
   parameter int ADDRW = crossbar_pkg::ADDRW,
   parameter int WL    = crossbar_pkg::WL,
   parameter int RDLAT = 1                  // legal range 1..4
) (
   input logic             clk,
   input logic             rst,
   crossbar4x4read_if.slave bus
);
   import crossbar_pkg::*;

   logic [BSELW-1:0] bsel [NPORT];
   logic [NPORT-1:0] conflict;
   logic [NPORT-1:0] grant;
   tag_t             tag_in  [NPORT];
   tag_t             tag_out [NPORT];

   always_comb begin
      for (int i = 0; i < NPORT; i++) bsel[i] = banksel_of(bus.address[i][BSELW-1:0]);
   end

   // A lower-index requester blocks the bank even when rows match: no broadcast.
   always_comb begin
      conflict = '0;
      for (int i = 1; i < NPORT; i++) begin
         for (int j = 0; j < i; j++) begin
            if (bus.req[j] && (bsel[j] == bsel[i])) conflict[i] = 1'b1;
         end
      end
      grant     = bus.req & ~conflict & {NPORT{bus.ena & ~rst}};
      bus.stall = bus.req & ~grant;
   end

   always_comb begin
      bus.bankren = '0;
      for (int b = 0; b < NBANK; b++) bus.addressout[b] = '0;
      for (int i = NPORT - 1; i >= 0; i--) begin
         if (grant[i]) begin
            bus.bankren[bsel[i]]    = 1'b1;
            bus.addressout[bsel[i]] = bus.address[i][ADDRW-1:BSELW];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         tag_in[i].valid = grant[i];
         tag_in[i].bsel  = bsel[i];
      end
   end

   for (genvar i = 0; i < NPORT; i++) begin : g_tag
      crossbar_rd_tagpipe #(.RDLAT(RDLAT)) u_tagpipe (
         .clk  (clk),
         .rst  (rst),
         .din  (tag_in[i]),
         .dout (tag_out[i])
      );
   end

   // The tag leaves the pipe in the same cycle its bank presents the data.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rdvalid <= '0;
         for (int i = 0; i < NPORT; i++) bus.rddata[i] <= '0;
      end else begin
         for (int i = 0; i < NPORT; i++) begin
            bus.rdvalid[i] <= tag_out[i].valid;
            if (tag_out[i].valid) bus.rddata[i] <= bus.bankdata[tag_out[i].bsel];
         end
      end
   end

endmodule

// File: tb/tb_crossbar4x4read.sv
// Bench for crossbar4x4read: three instances (RDLAT 1,2,3) share one stimulus
// stream; a reference model fills per-port expected queues, monitors drain them.
module tb_crossbar4x4read;
   import crossbar_pkg::*;

   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int NDUT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          drv_ena = 1'b0;
   logic [3:0]    drv_req = '0;
   logic [AW-1:0] drv_addr [4] = '{default: '0};

   logic [3:0]    exp_stall = '0;
   logic [3:0]    exp_ren   = '0;
   logic [3:0]    exp_grant = '0;
   logic [AW-3:0] exp_aout [4] = '{default: '0};

   logic [63:0]   exp_q [NDUT][4][$];
   logic [DW-1:0] last_data [NDUT][4];

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   function automatic logic [DW-1:0] bank_word(input logic [AW-3:0] row, input int b);
      return DW'(row) * 16 + DW'(b);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
      end
   endtask

   // Reference: per bank, the first requesting port (lowest index) claims it.
   task automatic model_eval();
      bit claimed [4];
      int b;
      for (int k = 0; k < 4; k++) begin
         claimed[k] = 1'b0;
         exp_aout[k] = '0;
      end
      exp_grant = '0;
      exp_ren   = '0;
      for (int i = 0; i < 4; i++) begin
         if (drv_req[i]) begin
            b = int'(drv_addr[i][1:0]);
            if (!claimed[b]) begin
               claimed[b] = 1'b1;
               if (drv_ena && !rst) begin
                  exp_grant[i] = 1'b1;
                  exp_ren[b]   = 1'b1;
                  exp_aout[b]  = drv_addr[i][AW-1:2];
                  for (int g = 0; g < NDUT; g++)
                     exp_q[g][i].push_back({32'(cyc + g + 2), bank_word(drv_addr[i][AW-1:2], b)});
               end
            end
         end
      end
      exp_stall = drv_req & ~exp_grant;
   endtask

   task automatic issue(input logic [3:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                        input logic e, input logic rs);
      @(posedge clk);
      #1;
      drv_req = r;
      drv_addr[0] = a0; drv_addr[1] = a1; drv_addr[2] = a2; drv_addr[3] = a3;
      drv_ena = e;
      rst     = rs;
      model_eval();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) issue(4'h0, '0, '0, '0, '0, 1'b1, 1'b0);
   endtask

   // Requester contract: stalled ports keep req/address until granted.
   task automatic issue_held(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2, input logic [AW-1:0] a3);
      logic [3:0] r;
      r = 4'hf;
      for (int k = 0; k < 8 && r != 4'h0; k++) begin
         issue(r, a0, a1, a2, a3, 1'b1, 1'b0);
         r = r & ~exp_grant;
      end
   endtask

   for (genvar g = 0; g < NDUT; g++) begin : gen_dut
      crossbar4x4read_if #(.ADDRW(AW), .WL(DW)) bus ();

      logic [3:0]    h_ren [4]    = '{default: '0};
      logic [AW-3:0] h_row [4][4] = '{default: '{default: '0}};

      assign bus.ena     = drv_ena;
      assign bus.req     = drv_req;
      assign bus.address = drv_addr;

      // Bank memory model: word = row*16+bank, presented g+1 cycles after the read.
      always @(posedge clk) begin
         for (int d = 3; d > 0; d--) begin
            h_ren[d] <= h_ren[d-1];
            h_row[d] <= h_row[d-1];
         end
         h_ren[0] <= bus.bankren;
         h_row[0] <= bus.addressout;
      end

      always_comb begin
         for (int b = 0; b < 4; b++)
            bus.bankdata[b] = h_ren[g][b] ? bank_word(h_row[g][b], b) : (32'hDEAD_0000 | DW'(b));
      end

      crossbar4x4read #(.ADDRW(AW), .WL(DW), .RDLAT(g + 1)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      always @(negedge clk) begin
         logic [63:0] e;
         if (chk_en) begin
            check($sformatf("d%0d stall", g), 64'(bus.stall), 64'(exp_stall));
            check($sformatf("d%0d bankren", g), 64'(bus.bankren), 64'(exp_ren));
            for (int b = 0; b < 4; b++)
               check($sformatf("d%0d addressout%0d", g, b), 64'(bus.addressout[b]), 64'(exp_aout[b]));
            for (int p = 0; p < 4; p++) begin
               if (exp_q[g][p].size() != 0 && int'(exp_q[g][p][0][63:32]) == cyc) begin
                  e = exp_q[g][p].pop_front();
                  check($sformatf("d%0d rdvalid%0d", g, p), 64'(bus.rdvalid[p]), 64'(1));
                  check($sformatf("d%0d rddata%0d", g, p), 64'(bus.rddata[p]), 64'(e[31:0]));
                  last_data[g][p] = e[31:0];
               end else begin
                  check($sformatf("d%0d rdvalid%0d", g, p), 64'(bus.rdvalid[p]), 64'(0));
                  check($sformatf("d%0d rddata%0d hold", g, p), 64'(bus.rddata[p]), 64'(last_data[g][p]));
               end
            end
         end
         if (rst) begin
            for (int p = 0; p < 4; p++) begin
               exp_q[g][p].delete();
               last_data[g][p] = '0;
            end
         end
      end
   end

   initial begin
      logic [3:0]    r;
      logic [1:0]    perm [4];
      logic [1:0]    tmp;
      logic [AW-1:0] a [4];
      logic          e;
      int            j;

      issue(4'h0, '0, '0, '0, '0, 1'b0, 1'b1);
      issue(4'h0, '0, '0, '0, '0, 1'b0, 1'b1);
      chk_en = 1'b1;
      idle(2);

      // Distinct banks, all four ports issue together.
      issue(4'hf, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 1'b1, 1'b0);
      idle(5);

      // Full conflict on bank 1, then partial conflict on bank 0.
      issue_held(16'h0005, 16'h0009, 16'h000D, 16'h0011);
      idle(5);
      issue_held(16'h0004, 16'h0001, 16'h0008, 16'h0003);
      idle(5);

      // Global enable low: everything stalls, earlier reads still return.
      issue(4'hf, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 1'b1, 1'b0);
      issue(4'hf, 16'h0020, 16'h0021, 16'h0022, 16'h0023, 1'b0, 1'b0);
      issue(4'hf, 16'h0020, 16'h0021, 16'h0022, 16'h0023, 1'b0, 1'b0);
      issue(4'hf, 16'h0020, 16'h0021, 16'h0022, 16'h0023, 1'b1, 1'b0);
      idle(5);

      // Reset one cycle after a burst: in-flight reads are dropped.
      issue(4'hf, 16'h0104, 16'h0209, 16'h030E, 16'h0403, 1'b1, 1'b0);
      issue(4'h0, '0, '0, '0, '0, 1'b1, 1'b1);
      idle(5);
      issue(4'hf, 16'h0050, 16'h0061, 16'h0072, 16'h0083, 1'b1, 1'b0);
      idle(5);

      // Streaming with conflict-free random banks.
      for (int k = 0; k < 100; k++) begin
         for (int i = 0; i < 4; i++) perm[i] = 2'(i);
         for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
         end
         for (int i = 0; i < 4; i++) a[i] = {14'($urandom_range(0, 16383)), perm[i]};
         r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
         issue(r, a[0], a[1], a[2], a[3], 1'b1, 1'b0);
      end

      // Fully random traffic with conflicts and enable drops; stalled ports hold.
      for (int i = 0; i < 4; i++) a[i] = '0;
      for (int k = 0; k < 80; k++) begin
         r = exp_stall;
         for (int i = 0; i < 4; i++) begin
            if (!exp_stall[i]) begin
               r[i] = 1'($urandom_range(0, 1));
               a[i] = {14'($urandom_range(0, 16383)), 2'($urandom_range(0, 3))};
            end
         end
         e = ($urandom_range(0, 7) != 0);
         issue(r, a[0], a[1], a[2], a[3], e, 1'b0);
      end

      idle(8);
      for (int g = 0; g < NDUT; g++)
         for (int p = 0; p < 4; p++)
            check($sformatf("d%0d port%0d outstanding", g, p), 64'(exp_q[g][p].size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
